// File: rtl/swu_seq_pkg.sv
// Shared definitions for the sliding-window frame sequencer: state encoding
// and the beat-count derivations used to size the frame counters.
package swu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  function automatic int calc_in_beats(input int ifm_h, input int ifm_w,
                                       input int ifm_ch, input int simd);
    return (ifm_h * ifm_w * ifm_ch) / simd;
  endfunction

  function automatic int calc_out_beats(input int ofm_h, input int ofm_w,
                                        input int k_h, input int k_w,
                                        input int ifm_ch, input int simd);
    return (ofm_h * ofm_w * k_h * k_w * ifm_ch) / simd;
  endfunction

endpackage

// File: rtl/swu_frame_sequencer.sv
// Frame sequencer placed in front of a sliding-window unit: gates its streams
// per frame, counts beats, and resets the window unit between frames.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame in progress, streams gated off, waiting for enable
// ST_RUN   | frame active, streams passed through, beats counted
// ST_FLUSH | window unit held in reset for RST_CYCLES cycles
module swu_frame_sequencer
  import swu_seq_pkg::*;
#(
  parameter int SIMD          = 1,
  parameter int IP_PRECISION  = 4,
  parameter int MMV           = 1,
  parameter int IFMChannels   = 2,
  parameter int IFMWidth      = 5,
  parameter int IFMHeight     = 5,
  parameter int OFMWidth      = 3,
  parameter int OFMHeight     = 5,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int RST_CYCLES    = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              enable,
  input  logic                              abort,
  input  logic [SIMD*IP_PRECISION-1:0]      ip_data,
  input  logic                              ip_axis_tvalid,
  output logic                              ip_axis_tready,
  output logic [SIMD*IP_PRECISION-1:0]      swu_ip_data,
  output logic                              swu_ip_axis_tvalid,
  input  logic                              swu_ip_axis_tready,
  input  logic [MMV*SIMD*IP_PRECISION-1:0]  swu_op_data,
  input  logic                              swu_op_axis_tvalid,
  output logic                              swu_op_axis_tready,
  output logic [MMV*SIMD*IP_PRECISION-1:0]  op_data,
  output logic                              op_axis_tvalid,
  input  logic                              op_axis_tready,
  output logic                              swu_resetn,
  output logic                              busy,
  output logic                              frame_done,
  output logic [15:0]                       frames_completed,
  output logic                              aborted
);

  localparam int IN_BEATS  = calc_in_beats(IFMHeight, IFMWidth, IFMChannels, SIMD);
  localparam int OUT_BEATS = calc_out_beats(OFMHeight, OFMWidth, KERNEL_HEIGHT,
                                            KERNEL_WIDTH, IFMChannels, SIMD);
  localparam int IW = $clog2(IN_BEATS + 1);
  localparam int OW = $clog2(OUT_BEATS + 1);
  localparam int FW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [IW-1:0] IN_LIMIT   = IW'(IN_BEATS);
  localparam logic [OW-1:0] OUT_LAST   = OW'(OUT_BEATS - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(RST_CYCLES - 1);

  seq_state_e      state_q, state_d;
  logic [IW-1:0]   in_cnt_q, in_cnt_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frames_q, frames_d;
  logic            aborted_q, aborted_d;
  logic            swu_resetn_q, swu_resetn_d;

  logic            run;
  logic            in_open;
  logic            in_hs;
  logic            out_hs;
  logic            final_hs;

  assign swu_ip_data = ip_data;
  assign op_data     = swu_op_data;

  always_comb begin
    run     = (state_q == ST_RUN);
    in_open = (in_cnt_q < IN_LIMIT);

    swu_ip_axis_tvalid = run & ip_axis_tvalid & in_open;
    ip_axis_tready     = run & swu_ip_axis_tready & in_open;
    op_axis_tvalid     = run & swu_op_axis_tvalid;
    swu_op_axis_tready = run & op_axis_tready;

    in_hs    = ip_axis_tvalid & ip_axis_tready;
    out_hs   = op_axis_tvalid & op_axis_tready;
    final_hs = out_hs & (out_cnt_q == OUT_LAST);
  end

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    frame_done_d = 1'b0;
    frames_d     = frames_q;
    aborted_d    = aborted_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_RUN;
          aborted_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (in_hs)  in_cnt_d  = in_cnt_q + IW'(1);
        if (out_hs) out_cnt_d = out_cnt_q + OW'(1);
        // A final handshake wins over a coincident abort.
        if (final_hs) begin
          frame_done_d = 1'b1;
          frames_d     = frames_q + 16'd1;
          state_d      = ST_FLUSH;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_FLUSH;
        end
        if (state_d == ST_FLUSH) begin
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = '0;
          state_d     = enable ? ST_RUN : ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      default: begin
        state_d     = ST_FLUSH;
        flush_cnt_d = '0;
      end
    endcase

    swu_resetn_d = (state_d != ST_FLUSH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_FLUSH;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      frames_q     <= '0;
      aborted_q    <= 1'b0;
      swu_resetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      frame_done_q <= frame_done_d;
      frames_q     <= frames_d;
      aborted_q    <= aborted_d;
      swu_resetn_q <= swu_resetn_d;
    end
  end

  assign swu_resetn       = swu_resetn_q;
  assign busy             = (state_q != ST_IDLE);
  assign frame_done       = frame_done_q;
  assign frames_completed = frames_q;
  assign aborted          = aborted_q;

endmodule

// File: tb/tb_swu_frame_sequencer.sv
// Directed bench for swu_frame_sequencer with a stand-in window unit whose
// output data is a known function of its beat index.
module tb_swu_frame_sequencer;

  logic        clk = 1'b0;
  logic        resetn, enable, abort;
  logic [3:0]  ip_data;
  logic        ip_axis_tvalid, ip_axis_tready;
  logic [3:0]  swu_ip_data;
  logic        swu_ip_axis_tvalid, swu_ip_axis_tready;
  logic [3:0]  swu_op_data;
  logic        swu_op_axis_tvalid, swu_op_axis_tready;
  logic [3:0]  op_data;
  logic        op_axis_tvalid, op_axis_tready;
  logic        swu_resetn, busy, frame_done, aborted;
  logic [15:0] frames_completed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  swu_frame_sequencer #(
    .SIMD(1), .IP_PRECISION(4), .MMV(1),
    .IFMChannels(2), .IFMWidth(5), .IFMHeight(5),
    .OFMWidth(3), .OFMHeight(5), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3),
    .RST_CYCLES(4)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .abort(abort),
    .ip_data(ip_data), .ip_axis_tvalid(ip_axis_tvalid), .ip_axis_tready(ip_axis_tready),
    .swu_ip_data(swu_ip_data), .swu_ip_axis_tvalid(swu_ip_axis_tvalid),
    .swu_ip_axis_tready(swu_ip_axis_tready),
    .swu_op_data(swu_op_data), .swu_op_axis_tvalid(swu_op_axis_tvalid),
    .swu_op_axis_tready(swu_op_axis_tready),
    .op_data(op_data), .op_axis_tvalid(op_axis_tvalid), .op_axis_tready(op_axis_tready),
    .swu_resetn(swu_resetn), .busy(busy), .frame_done(frame_done),
    .frames_completed(frames_completed), .aborted(aborted)
  );

  // Stand-in window unit: emits beat k as k*3 (mod 16), restarts when reset.
  logic [15:0] k;
  always @(posedge clk) begin
    if (!swu_resetn) k <= '0;
    else if (swu_op_axis_tvalid && swu_op_axis_tready) k <= k + 16'd1;
  end
  assign swu_op_data = k[3:0] * 4'd3;

  // Monitor: per-frame beat counts since the last window-unit reset.
  int m = 0, n = 0, done_cnt = 0, data_err = 0, len_err = 0, in_over = 0;
  logic [3:0] exp_d;
  always @(posedge clk) begin
    if (swu_ip_data !== ip_data) data_err++;
    if (op_axis_tvalid && op_axis_tready) begin
      exp_d = 4'(m * 3);
      if (op_data !== exp_d) data_err++;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (m != 270) len_err++;
    end
    if (swu_resetn !== 1'b1) begin
      m = 0;
      n = 0;
    end else begin
      if (op_axis_tvalid && op_axis_tready) m++;
      if (ip_axis_tvalid && ip_axis_tready) begin
        n++;
        if (n > 50) in_over++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int low;
  int base_done;

  initial begin
    resetn = 1'b1; enable = 1'b0; abort = 1'b0; ip_data = 4'h3;
    ip_axis_tvalid = 1'b1; swu_ip_axis_tready = 1'b1;
    swu_op_axis_tvalid = 1'b1; op_axis_tready = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) tick();

    chk("rst_swu_resetn", swu_resetn, 0);
    chk("rst_ip_tready", ip_axis_tready, 0);
    chk("rst_swu_ip_tvalid", swu_ip_axis_tvalid, 0);
    chk("rst_op_tvalid", op_axis_tvalid, 0);
    chk("rst_swu_op_tready", swu_op_axis_tready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frames", frames_completed, 0);
    chk("rst_aborted", aborted, 0);

    // Reset release with enable high: window-unit reset low for 4 cycles.
    enable = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    low = 0;
    for (int i = 0; i < 20 && swu_resetn !== 1'b1; i++) begin
      low++;
      tick();
    end
    chk("rel_low_cycles", low, 4);
    chk("rel_busy", busy, 1);
    chk("rel_ip_tready", ip_axis_tready, 1);

    // Frame 1 at full throughput: 50 inputs, then input blocked.
    repeat (60) tick();
    chk("f1_in_blocked", ip_axis_tready, 0);
    chk("f1_still_run", op_axis_tvalid, 1);
    for (int i = 0; i < 1000 && frame_done !== 1'b1; i++) tick();
    chk("f1_done", frame_done, 1);
    chk("f1_out_beats", m, 270);
    chk("f1_in_beats", n, 50);
    chk("f1_frames", frames_completed, 1);
    tick();
    chk("f1_done_pulse", frame_done, 0);

    // Abort at out_cnt=100.
    for (int i = 0; i < 1000 && m != 100; i++) tick();
    chk("ab_reach_100", m, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_aborted", aborted, 1);
    chk("ab_no_done", frame_done, 0);
    low = 0;
    for (int i = 0; i < 20 && swu_resetn !== 1'b1; i++) begin
      low++;
      tick();
    end
    chk("ab_flush_cycles", low, 4);
    for (int i = 0; i < 1000 && frame_done !== 1'b1; i++) tick();
    chk("ab_next_done", frame_done, 1);
    chk("ab_next_beats", m, 270);
    chk("ab_frames", frames_completed, 2);
    chk("ab_sticky", aborted, 1);

    // Drop to idle, abort there is ignored, restart clears aborted.
    enable = 1'b0;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) tick();
    chk("idle_busy", busy, 0);
    chk("idle_op_tvalid", op_axis_tvalid, 0);
    chk("idle_ip_tready", ip_axis_tready, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ignored", busy, 0);
    chk("idle_aborted_kept", aborted, 1);
    enable = 1'b1;
    tick();
    chk("restart_busy", busy, 1);
    chk("restart_aborted_clr", aborted, 0);

    // Abort coincident with the final output handshake.
    for (int i = 0; i < 1000 && m != 269; i++) tick();
    chk("co_reach_269", m, 269);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("co_done", frame_done, 1);
    chk("co_aborted", aborted, 0);
    chk("co_frames", frames_completed, 3);
    tick();
    chk("co_done_count", done_cnt, 3);

    // Three back-to-back frames with random backpressure.
    base_done = done_cnt;
    for (int i = 0; i < 9000 && done_cnt < base_done + 3; i++) begin
      @(negedge clk);
      ip_data            = 4'($urandom);
      ip_axis_tvalid     = ($urandom_range(0, 3) != 0);
      op_axis_tready     = ($urandom_range(0, 3) != 0);
      swu_op_axis_tvalid = ($urandom_range(0, 3) != 0);
      swu_ip_axis_tready = ($urandom_range(0, 3) != 0);
    end
    ip_axis_tvalid = 1'b1; op_axis_tready = 1'b1;
    swu_op_axis_tvalid = 1'b1; swu_ip_axis_tready = 1'b1;
    #1;
    chk("rnd_done_count", done_cnt, base_done + 3);
    chk("rnd_frames", frames_completed, 6);
    chk("rnd_len_err", len_err, 0);
    chk("rnd_in_over", in_over, 0);
    chk("rnd_data_err", data_err, 0);

    // resetn pulse mid-frame at in_cnt=30.
    for (int i = 0; i < 100 && swu_resetn !== 1'b0; i++) tick();
    for (int i = 0; i < 1000 && n != 30; i++) tick();
    chk("mr_reach_30", n, 30);
    base_done = done_cnt;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mr_swu_resetn", swu_resetn, 0);
    chk("mr_ip_tready", ip_axis_tready, 0);
    chk("mr_swu_ip_tvalid", swu_ip_axis_tvalid, 0);
    chk("mr_op_tvalid", op_axis_tvalid, 0);
    chk("mr_swu_op_tready", swu_op_axis_tready, 0);
    chk("mr_frames", frames_completed, 0);
    chk("mr_aborted", aborted, 0);
    repeat (3) tick();
    chk("mr_no_done", done_cnt, base_done);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    low = 0;
    for (int i = 0; i < 20 && swu_resetn !== 1'b1; i++) begin
      low++;
      tick();
    end
    chk("mr_flush_cycles", low, 4);
    for (int i = 0; i < 1000 && frame_done !== 1'b1; i++) tick();
    chk("mr_done", frame_done, 1);
    chk("mr_out_beats", m, 270);
    chk("mr_in_beats", n, 50);
    chk("mr_frames_after", frames_completed, 1);
    tick();
    chk("mr_done_count", done_cnt, base_done + 1);
    chk("final_data_err", data_err, 0);
    chk("final_len_err", len_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
